// File: rtl/irrigation_pkg.sv
// Shared constants for the irrigation plant model: fault-mode codes and
// the emulator's run/freeze state encoding.
package irrigation_pkg;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_HIGH_STUCK = 2'b01;
  localparam logic [1:0] FAULT_MID_STUCK  = 2'b10;
  localparam logic [1:0] FAULT_FREEZE     = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: tick_o is high for one cycle out of every TICK_DIV,
// so the first tick is sampled on the TICK_DIV-th rising edge after reset.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  // count 0..TICK_DIV-1 and wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign tick_o = (tick_cnt == LAST);

endmodule

// File: rtl/water_tank_emulator.sv
// Tank plant model: integrates actuator commands into a clamped volume at a
// divided tick rate and drives float-switch outputs with optional faults.
//
// state     | meaning
// ST_RUN    | volume and flags follow the commands on every tick
// ST_FROZEN | fault mode 11 active; volume, overflow and dry hold
module water_tank_emulator
  import irrigation_pkg::*;
#(
  parameter int VOL_W          = 6,
  parameter int CAPACITY       = 63,
  parameter int INIT_VOL       = 0,
  parameter int LOW_THR        = 16,
  parameter int MID_THR        = 32,
  parameter int HIGH_THR       = 56,
  parameter int TICK_DIV       = 4,
  parameter int INLET_RATE     = 3,
  parameter int SPRINKLER_RATE = 2,
  parameter int DRIP_RATE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inlet_valve_i,
  input  logic             sprinkler_i,
  input  logic             drip_i,
  input  logic [1:0]       fault_mode_i,
  output logic             high_level_indicator_o,
  output logic             middle_level_indicator_o,
  output logic             low_level_indicator_o,
  output logic [VOL_W-1:0] volume_o,
  output logic             level_change_o,
  output logic             overflow_o,
  output logic             dry_o
);

  // two extra bits give room for both the sign and the overshoot past CAPACITY
  localparam int SW = VOL_W + 2;

  state_t           state;
  logic             tick;
  logic             freeze;
  logic [VOL_W-1:0] vol;
  logic [VOL_W-1:0] vol_next;
  logic [SW-1:0]    net;
  logic [SW-1:0]    sum;
  logic             sum_neg;
  logic             sum_over;
  logic [2:0]       sens;
  logic [2:0]       sens_next;
  logic             overflow;
  logic             dry;
  logic             level_change;

  function automatic logic [2:0] level_compare(input logic [VOL_W-1:0] v);
    return {v >= VOL_W'(HIGH_THR), v >= VOL_W'(MID_THR), v >= VOL_W'(LOW_THR)};
  endfunction

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // the freeze mode is sampled on the tick edge just like the commands
  assign freeze = (fault_mode_i == FAULT_FREEZE);

  // signed net flow for this tick (two's complement at SW bits)
  always_comb begin
    net = '0;
    if (inlet_valve_i) net = net + SW'(INLET_RATE);
    if (sprinkler_i)   net = net - SW'(SPRINKLER_RATE);
    if (drip_i)        net = net - SW'(DRIP_RATE);
  end

  assign sum      = {2'b00, vol} + net;
  assign sum_neg  = sum[SW-1];
  assign sum_over = !sum_neg && (sum > SW'(CAPACITY));

  // clamp the updated volume to [0, CAPACITY]
  always_comb begin
    vol_next = sum[VOL_W-1:0];
    if (sum_neg)       vol_next = '0;
    else if (sum_over) vol_next = VOL_W'(CAPACITY);
  end

  // sensor compare with fault overrides applied on top
  always_comb begin
    sens_next = level_compare(vol);
    if (fault_mode_i == FAULT_HIGH_STUCK) sens_next[2] = 1'b1;
    if (fault_mode_i == FAULT_MID_STUCK)  sens_next[1] = 1'b0;
  end

  // run/freeze FSM plus the volume, flag and sensor registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      vol          <= VOL_W'(INIT_VOL);
      sens         <= level_compare(VOL_W'(INIT_VOL));
      level_change <= 1'b0;
      overflow     <= 1'b0;
      dry          <= 1'b0;
    end else begin
      case (state)
        ST_RUN:    if (freeze)  state <= ST_FROZEN;
        ST_FROZEN: if (!freeze) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase

      if (tick && !freeze) begin
        vol <= vol_next;
        dry <= (vol == '0) && (sprinkler_i || drip_i);
        if (sum_over) overflow <= 1'b1;
      end

      sens         <= sens_next;
      level_change <= (sens_next != sens);
    end
  end

  assign high_level_indicator_o   = sens[2];
  assign middle_level_indicator_o = sens[1];
  assign low_level_indicator_o    = sens[0];
  assign volume_o                 = vol;
  assign level_change_o           = level_change;
  assign overflow_o               = overflow;
  assign dry_o                    = dry;

endmodule

// File: tb/tb_water_tank_emulator.sv
// Self-checking bench for water_tank_emulator: directed fill/drain/fault/reset
// scenario followed by randomized commands, all against an integer tank model.
module tb_water_tank_emulator;

  localparam int CAP   = 63;
  localparam int LOWT  = 16;
  localparam int MIDT  = 32;
  localparam int HIGHT = 56;
  localparam int DIV   = 4;
  localparam int R_IN  = 3;
  localparam int R_SPR = 2;
  localparam int R_DRP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inlet = 1'b0;
  logic       sprinkler = 1'b0;
  logic       drip = 1'b0;
  logic [1:0] fault = 2'b00;
  logic       high_lvl, mid_lvl, low_lvl;
  logic [5:0] volume;
  logic       level_change, overflow, dry;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_edge;
  int m_vol;
  int m_sens;
  int m_lc;
  int m_ovf;
  int m_dry;

  water_tank_emulator dut (
    .clk                     (clk),
    .rst                     (rst),
    .inlet_valve_i           (inlet),
    .sprinkler_i             (sprinkler),
    .drip_i                  (drip),
    .fault_mode_i            (fault),
    .high_level_indicator_o  (high_lvl),
    .middle_level_indicator_o(mid_lvl),
    .low_level_indicator_o   (low_lvl),
    .volume_o                (volume),
    .level_change_o          (level_change),
    .overflow_o              (overflow),
    .dry_o                   (dry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, m_edge, got, exp);
    end
  endtask

  function automatic int sensors_of(input int v, input int f, input bit use_fault);
    int h, m, l;
    h = (v >= HIGHT) ? 1 : 0;
    m = (v >= MIDT) ? 1 : 0;
    l = (v >= LOWT) ? 1 : 0;
    if (use_fault && f == 1) h = 1;
    if (use_fault && f == 2) m = 0;
    return h * 4 + m * 2 + l;
  endfunction

  task automatic model_reset();
    m_edge = 0;
    m_vol  = 0;
    m_sens = sensors_of(0, 0, 1'b0);
    m_lc   = 0;
    m_ovf  = 0;
    m_dry  = 0;
  endtask

  // one rising edge of the tank, using the inputs held across that edge
  task automatic model_edge();
    int new_sens;
    int s;
    m_edge++;
    new_sens = sensors_of(m_vol, int'(fault), 1'b1);
    m_lc = (new_sens != m_sens) ? 1 : 0;
    if ((m_edge % DIV) == 0 && fault != 2'b11) begin
      s = m_vol;
      if (inlet)     s += R_IN;
      if (sprinkler) s -= R_SPR;
      if (drip)      s -= R_DRP;
      m_dry = (m_vol == 0 && (sprinkler || drip)) ? 1 : 0;
      if (s > CAP) begin
        m_ovf = 1;
        s = CAP;
      end
      if (s < 0) s = 0;
      m_vol = s;
    end
    m_sens = new_sens;
  endtask

  task automatic compare_all();
    check("volume", int'(volume), m_vol);
    check("high", int'(high_lvl), (m_sens >> 2) & 1);
    check("middle", int'(mid_lvl), (m_sens >> 1) & 1);
    check("low", int'(low_lvl), m_sens & 1);
    check("level_change", int'(level_change), m_lc);
    check("overflow", int'(overflow), m_ovf);
    check("dry", int'(dry), m_dry);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int n);
    while (m_edge < n) step();
  endtask

  // called at a negedge: reset hits between edges and must act at once
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_volume", int'(volume), 0);
    check("rst_sensors", int'({high_lvl, mid_lvl, low_lvl}), 0);
    check("rst_flags", int'({level_change, overflow, dry}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // fill
    inlet = 1'b1;
    run_to(4);
    check("fill_e4_vol", int'(volume), 3);
    run_to(24);
    check("fill_e24_vol", int'(volume), 18);
    check("fill_e24_low", int'(low_lvl), 0);
    run_to(25);
    check("fill_e25_low", int'(low_lvl), 1);
    check("fill_e25_lc", int'(level_change), 1);
    run_to(26);
    check("fill_e26_lc", int'(level_change), 0);
    run_to(45);
    check("fill_e45_vol", int'(volume), 33);
    check("fill_e45_mid", int'(mid_lvl), 1);
    run_to(77);
    check("fill_e77_vol", int'(volume), 57);
    check("fill_e77_high", int'(high_lvl), 1);

    // overflow
    run_to(84);
    check("ovf_e84_vol", int'(volume), 63);
    check("ovf_e84_flag", int'(overflow), 0);
    run_to(88);
    check("ovf_e88_vol", int'(volume), 63);
    check("ovf_e88_flag", int'(overflow), 1);

    // drain, then balanced flow, then drain to empty
    inlet = 1'b0;
    sprinkler = 1'b1;
    drip = 1'b1;
    run_to(92);
    check("drain_e92_vol", int'(volume), 60);
    check("drain_ovf_sticky", int'(overflow), 1);
    inlet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("balanced_vol", int'(volume), 60);
      check("balanced_lc", int'(level_change), 0);
    end
    inlet = 1'b0;
    run_to(180);
    check("drain_e180_vol", int'(volume), 0);
    check("drain_e180_dry", int'(dry), 0);
    run_to(184);
    check("drain_e184_dry", int'(dry), 1);
    sprinkler = 1'b0;
    drip = 1'b0;
    run_to(188);
    check("drain_e188_dry", int'(dry), 0);

    // faults
    fault = 2'b01;
    step();
    check("fault01_sens", int'({high_lvl, mid_lvl, low_lvl}), 3'b100);
    fault = 2'b11;
    inlet = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("freeze_vol", int'(volume), 0);
    fault = 2'b00;
    run_to(213);
    check("resume_vol", int'(volume), 3);

    // reset mid-operation with the middle sensor wet
    while (m_vol < 40 && m_edge < 400) step();
    check("pre_rst_mid", int'(mid_lvl), 1);
    do_reset();
    run_to(3);
    check("refill_e3_vol", int'(volume), 0);
    run_to(4);
    check("refill_e4_vol", int'(volume), 3);

    // randomized commands against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        inlet     = ($urandom_range(0, 2) != 0);
        sprinkler = 1'($urandom_range(0, 1));
        drip      = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0)
        fault = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
